// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared fetch-pipeline definitions: the controller state encoding, the NOP
// bundle used when IF/ID is flushed, the default widths and a saturating
// counter helper.
package fetch_stall_ctrl_pkg;

    localparam int DEF_PC_W    = 8;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_CTRL_W  = 8;

    // A flushed IF/ID slot carries an all-zero bundle.
    localparam logic [DEF_INSTR_W-1:0] NOP_BUNDLE = {DEF_INSTR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'h0001;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// Bundle of hazard-unit controls, branch redirect, instruction-memory data
// and the IF/ID outputs shared between the fetch controller and its users.
interface fetch_stall_ctrl_if
    import fetch_stall_ctrl_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int CTRL_W  = DEF_CTRL_W
) ();

    logic               PCWrite;
    logic               IF_IDWrite;
    logic               ControlMux;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] imem_data;
    logic [CTRL_W-1:0]  ctrl_in;

    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic [PC_W-1:0]    if_id_pc;
    logic               if_id_valid;
    logic [CTRL_W-1:0]  ctrl_out;
    logic [15:0]        stall_cnt;
    logic [1:0]         state;

    // Hazard unit / memory side: drives the controls, observes the pipeline.
    modport master (
        output PCWrite, IF_IDWrite, ControlMux, branch_taken, branch_target,
               imem_data, ctrl_in,
        input  pc, if_id_instr, if_id_pc, if_id_valid, ctrl_out, stall_cnt, state
    );

    // Fetch controller side.
    modport slave (
        input  PCWrite, IF_IDWrite, ControlMux, branch_taken, branch_target,
               imem_data, ctrl_in,
        output pc, if_id_instr, if_id_pc, if_id_valid, ctrl_out, stall_cnt, state
    );

endinterface

// File: rtl/fetch_stall_ctrl_if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP marked invalid, load captures
// the fetched bundle, otherwise every field holds.
module if_id_reg
    import fetch_stall_ctrl_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;
    logic               r_valid;

    // Flush wins over load so a redirect always kills the wrong-path slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= {INSTR_W{1'b0}};
            r_pc    <= {PC_W{1'b0}};
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= INSTR_W'(NOP_BUNDLE);
            r_pc    <= i_pc;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage controller: owns the PC, the RUN/STALL/FLUSH state machine and
// the stall counter, drives the IF/ID register and gates the ID/EX controls.
module fetch_stall_ctrl
    import fetch_stall_ctrl_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int CTRL_W  = DEF_CTRL_W
) (
    input  logic               clk,
    input  logic               reset,
    fetch_stall_ctrl_if.slave  bus
);

    logic [PC_W-1:0]    r_pc;
    state_e             r_state;
    logic [15:0]        r_stall_cnt;

    logic [INSTR_W-1:0] w_ifid_instr;
    logic [PC_W-1:0]    w_ifid_pc;
    logic               w_ifid_valid;
    logic [CTRL_W-1:0]  w_ctrl_out;

    // State, PC and stall counter; a taken branch overrides both hold requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= {PC_W{1'b0}};
            r_state     <= ST_RUN;
            r_stall_cnt <= 16'h0000;
        end else if (bus.branch_taken) begin
            r_pc    <= bus.branch_target;
            r_state <= ST_FLUSH;
        end else begin
            case (r_state)
                // FLUSH fetches the redirect target exactly like RUN does.
                ST_RUN, ST_FLUSH: begin
                    if (bus.PCWrite) begin
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= ST_RUN;
                    end else begin
                        r_state     <= ST_STALL;
                        r_stall_cnt <= sat_inc16(r_stall_cnt);
                    end
                end
                // The held PC is fetched on release, so nothing is lost or repeated.
                ST_STALL: begin
                    if (bus.PCWrite) begin
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= ST_RUN;
                    end else begin
                        r_state     <= ST_STALL;
                        r_stall_cnt <= sat_inc16(r_stall_cnt);
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (bus.IF_IDWrite),
        .i_flush (bus.branch_taken),
        .i_instr (bus.imem_data),
        .i_pc    (r_pc),
        .o_instr (w_ifid_instr),
        .o_pc    (w_ifid_pc),
        .o_valid (w_ifid_valid)
    );

    // Bubble into ID/EX when the hazard unit asks or IF/ID holds no real bundle.
    always_comb begin
        w_ctrl_out = {CTRL_W{1'b0}};
        if (bus.ControlMux && w_ifid_valid) begin
            w_ctrl_out = bus.ctrl_in;
        end else begin
            w_ctrl_out = {CTRL_W{1'b0}};
        end
    end

    assign bus.pc          = r_pc;
    assign bus.state       = r_state;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.if_id_instr = w_ifid_instr;
    assign bus.if_id_pc    = w_ifid_pc;
    assign bus.if_id_valid = w_ifid_valid;
    assign bus.ctrl_out    = w_ctrl_out;

endmodule
